// File: rtl/decode_pipe_if.sv
// Handshake bundle between fetch, decode_pipe and execute.
// The slave modport is the decode stage; the master modport is its environment.
interface decode_pipe_if #(
   parameter int ADDRESS_BITS   = 16,
   parameter int PERF_CNT_WIDTH = 16
);
   logic                      in_valid;
   logic                      in_ready;
   logic [ADDRESS_BITS-1:0]   in_PC;
   logic [31:0]               in_instruction;
   logic                      flush;
   logic                      out_valid;
   logic                      out_ready;
   logic [ADDRESS_BITS-1:0]   out_PC;
   logic [4:0]                read_sel1;
   logic [4:0]                read_sel2;
   logic [4:0]                write_sel;
   logic                      wEn;
   logic                      mem_wEn;
   logic                      wb_sel;
   logic                      branch_op;
   logic [1:0]                op_A_sel;
   logic                      op_B_sel;
   logic [31:0]               imm32;
   logic [5:0]                ALU_Control;
   logic                      jal_taken;
   logic [ADDRESS_BITS-1:0]   JAL_target;
   logic                      illegal;
   logic [PERF_CNT_WIDTH-1:0] stall_count;

   modport master (
      output in_valid, in_PC, in_instruction, flush, out_ready,
      input  in_ready, out_valid, out_PC, read_sel1, read_sel2, write_sel,
             wEn, mem_wEn, wb_sel, branch_op, op_A_sel, op_B_sel, imm32,
             ALU_Control, jal_taken, JAL_target, illegal, stall_count
   );

   modport slave (
      input  in_valid, in_PC, in_instruction, flush, out_ready,
      output in_ready, out_valid, out_PC, read_sel1, read_sel2, write_sel,
             wEn, mem_wEn, wb_sel, branch_op, op_A_sel, op_B_sel, imm32,
             ALU_Control, jal_taken, JAL_target, illegal, stall_count
   );
endinterface

// File: rtl/decode_pipe.sv
// Handshaked RV32I decode stage with a one-entry output register, load-use bubble and flush.
// Optional macro DECODE_ILLEGAL_TRAP_EN flags unsupported opcodes and suppresses their side effects.
module decode_pipe #(
   parameter int                      ADDRESS_BITS   = 16,
   parameter int                      PERF_CNT_WIDTH = 16,
   parameter logic [ADDRESS_BITS-1:0] RESET_PC_FIELD = '0
) (
   input logic          clock,
   input logic          reset,
   decode_pipe_if.slave bus
);
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef struct packed {
      logic [ADDRESS_BITS-1:0] pc;
      logic [4:0]              rs1;
      logic [4:0]              rs2;
      logic [4:0]              rd;
      logic                    wen;
      logic                    mem_wen;
      logic                    wb_sel;
      logic                    branch_op;
      logic [1:0]              op_a;
      logic                    op_b;
      logic [31:0]             imm;
      logic [5:0]              alu;
      logic                    jal;
      logic [ADDRESS_BITS-1:0] jal_target;
      logic                    illegal;
      logic                    is_load;
   } ctrl_t;

   function automatic logic [PERF_CNT_WIDTH-1:0] sat_inc(input logic [PERF_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [31:0]               ins;
   logic [6:0]                opcode;
   logic [2:0]                funct3;
   logic signed [31:0]        imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0]               shamt;
   logic                      uses_rs1, uses_rs2, hazard, accept, xfer, in_ready;
   ctrl_t                     dec_p0, ctrl_p1;
   logic                      vld_p1;
   logic                      load_pending;
   logic [4:0]                load_rd;
   logic [PERF_CNT_WIDTH-1:0] stall_cnt;

   assign ins    = bus.in_instruction;
   assign opcode = ins[6:0];
   assign funct3 = ins[14:12];
   assign imm_i  = {{20{ins[31]}}, ins[31:20]};
   assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
   assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_u  = {ins[31:12], 12'b0};
   assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   assign shamt  = {27'b0, ins[24:20]};

   // Stage 0: combinational decode of the presented instruction
   always_comb begin
      dec_p0      = '0;
      dec_p0.pc   = bus.in_PC;
      dec_p0.rs1  = ins[19:15];
      dec_p0.rs2  = ins[24:20];
      dec_p0.rd   = ins[11:7];
      dec_p0.wen  = 1'b1;
      dec_p0.imm  = imm_j;
      dec_p0.alu  = 6'b111111;
      case (opcode)
         OP_R:      begin dec_p0.alu = {2'b00, ins[30], funct3}; dec_p0.imm = '0; end
         OP_I:      begin
            dec_p0.alu  = (funct3 == 3'b101) ? {2'b00, ins[30], funct3} : {3'b000, funct3};
            dec_p0.op_b = 1'b1;
            dec_p0.imm  = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt : imm_i;
         end
         OP_LOAD:   begin
            dec_p0.alu = '0; dec_p0.op_b = 1'b1; dec_p0.imm = imm_i;
            dec_p0.wb_sel = 1'b1; dec_p0.is_load = 1'b1;
         end
         OP_STORE:  begin
            dec_p0.alu = '0; dec_p0.op_b = 1'b1; dec_p0.imm = imm_s;
            dec_p0.wen = 1'b0; dec_p0.mem_wen = 1'b1;
         end
         OP_BRANCH: begin
            dec_p0.alu = {3'b010, funct3}; dec_p0.imm = imm_b;
            dec_p0.wen = 1'b0; dec_p0.branch_op = 1'b1;
         end
         OP_JAL:    begin dec_p0.alu = 6'b011111; dec_p0.op_a = 2'b10; dec_p0.jal = 1'b1; end
         OP_JALR:   begin dec_p0.op_a = 2'b10; dec_p0.op_b = 1'b1; dec_p0.imm = imm_i; end
         OP_AUIPC:  begin dec_p0.alu = '0; dec_p0.op_a = 2'b01; dec_p0.op_b = 1'b1; dec_p0.imm = imm_u; end
         OP_LUI:    begin dec_p0.alu = '0; dec_p0.op_a = 2'b11; dec_p0.op_b = 1'b1; dec_p0.imm = imm_u; end
         default:   ;
      endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (!(opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
                           OP_AUIPC, OP_LUI}) || ins[1:0] != 2'b11) begin
         dec_p0.illegal   = 1'b1;
         dec_p0.wen       = 1'b0;
         dec_p0.mem_wen   = 1'b0;
         dec_p0.branch_op = 1'b0;
         dec_p0.jal       = 1'b0;
      end
`else
      dec_p0.illegal = 1'b0;
`endif
      dec_p0.jal_target = bus.in_PC + imm_j[ADDRESS_BITS-1:0];
   end

   // Only the instruction right after a transferred load is compared against its rd
   assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
   assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
   assign hazard   = load_pending && bus.in_valid &&
                     ((uses_rs1 && ins[19:15] == load_rd) || (uses_rs2 && ins[24:20] == load_rd));
   assign in_ready = !reset && (!vld_p1 || bus.out_ready) && !hazard && !bus.flush;
   assign accept   = bus.in_valid && in_ready;
   assign xfer     = vld_p1 && bus.out_ready;

   // Stage 1: output register and hazard/perf state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_p1       <= 1'b0;
         ctrl_p1      <= '0;
         ctrl_p1.pc   <= RESET_PC_FIELD;
         load_pending <= 1'b0;
         load_rd      <= '0;
         stall_cnt    <= '0;
      end else begin
         if (accept)
            ctrl_p1 <= dec_p0;
         if (bus.flush)
            vld_p1 <= 1'b0;
         else if (accept)
            vld_p1 <= 1'b1;
         else if (xfer)
            vld_p1 <= 1'b0;
         load_pending <= !bus.flush && xfer && ctrl_p1.is_load && (ctrl_p1.rd != 5'd0);
         if (xfer && ctrl_p1.is_load && (ctrl_p1.rd != 5'd0))
            load_rd <= ctrl_p1.rd;
         if (hazard && !bus.flush)
            stall_cnt <= sat_inc(stall_cnt);
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = vld_p1;
   assign bus.out_PC      = ctrl_p1.pc;
   assign bus.read_sel1   = ctrl_p1.rs1;
   assign bus.read_sel2   = ctrl_p1.rs2;
   assign bus.write_sel   = ctrl_p1.rd;
   assign bus.wEn         = ctrl_p1.wen;
   assign bus.mem_wEn     = ctrl_p1.mem_wen;
   assign bus.wb_sel      = ctrl_p1.wb_sel;
   assign bus.branch_op   = ctrl_p1.branch_op;
   assign bus.op_A_sel    = ctrl_p1.op_a;
   assign bus.op_B_sel    = ctrl_p1.op_b;
   assign bus.imm32       = ctrl_p1.imm;
   assign bus.ALU_Control = ctrl_p1.alu;
   assign bus.jal_taken   = ctrl_p1.jal;
   assign bus.JAL_target  = ctrl_p1.jal_target;
   assign bus.illegal     = ctrl_p1.illegal;
   assign bus.stall_count = stall_cnt;
endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: directed scenarios plus randomized traffic
// against a cycle-level reference model of the handshake, hazard and decode rules.
module tb_decode_pipe;
   localparam int          AB     = 16;
   localparam int          PW     = 4;
   localparam logic [15:0] RST_PC = 16'h0100;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [31:0] LW_X6  = 32'h0000A303;
   localparam logic [31:0] LW_X0  = 32'h0000A003;
   localparam logic [31:0] ADDI8  = 32'h00100413;
   localparam logic [31:0] ADD_X6 = 32'h002303B3;
   localparam logic [31:0] ADD_X0 = 32'h002003B3;

   logic clock = 1'b0;
   logic reset;

   decode_pipe_if #(.ADDRESS_BITS(AB), .PERF_CNT_WIDTH(PW)) bus ();

   decode_pipe #(.ADDRESS_BITS(AB), .PERF_CNT_WIDTH(PW), .RESET_PC_FIELD(RST_PC)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [15:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        wen;
      logic        mem_wen;
      logic        wb_sel;
      logic        branch_op;
      logic [1:0]  op_a;
      logic        op_b;
      logic [31:0] imm;
      logic [5:0]  alu;
      logic        jal;
      logic [15:0] jtgt;
      logic        illegal;
   } fields_t;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic        m_valid;
   fields_t     m_out;
   logic [6:0]  m_opc;
   logic        m_pending;
   logic [4:0]  m_rd;
   logic [3:0]  m_stall;
   logic        obs_ready, exp_ready;

   function automatic logic uses1(input logic [6:0] op);
      return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
   endfunction

   function automatic logic uses2(input logic [6:0] op);
      return op == OP_R || op == OP_STORE || op == OP_BRANCH;
   endfunction

   function automatic fields_t ref_decode(input logic [31:0] ins, input logic [15:0] pc);
      fields_t    f;
      int         ii, is, ib, iu, ij;
      logic [6:0] op;
      logic [2:0] f3;
      op = ins[6:0];
      f3 = ins[14:12];
      ii = $signed(ins[31:20]);
      is = $signed({ins[31:25], ins[11:7]});
      ib = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      iu = {ins[31:12], 12'b0};
      ij = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      f = '0;
      f.pc = pc; f.rs1 = ins[19:15]; f.rs2 = ins[24:20]; f.rd = ins[11:7];
      f.wen = !(op == OP_STORE || op == OP_BRANCH);
      f.jtgt = 16'(pc + ij);
      case (op)
         OP_R:      begin f.alu = {2'b00, ins[30], f3}; f.imm = 0; end
         OP_I:      begin
            f.op_b = 1;
            if (f3 == 3'd1 || f3 == 3'd5) f.imm = {27'd0, ins[24:20]}; else f.imm = ii;
            if (f3 == 3'd5) f.alu = {2'b00, ins[30], f3}; else f.alu = {3'b000, f3};
         end
         OP_LOAD:   begin f.op_b = 1; f.imm = ii; f.wb_sel = 1; end
         OP_STORE:  begin f.op_b = 1; f.imm = is; f.mem_wen = 1; end
         OP_BRANCH: begin f.imm = ib; f.branch_op = 1; f.alu = {3'b010, f3}; end
         OP_JAL:    begin f.imm = ij; f.op_a = 2'b10; f.alu = 6'b011111; f.jal = 1; end
         OP_JALR:   begin f.imm = ii; f.op_a = 2'b10; f.op_b = 1; f.alu = 6'b111111; end
         OP_AUIPC:  begin f.imm = iu; f.op_a = 2'b01; f.op_b = 1; end
         OP_LUI:    begin f.imm = iu; f.op_a = 2'b11; f.op_b = 1; end
         default:   begin f.imm = ij; f.alu = 6'b111111; end
      endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (!(op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI})
          || ins[1:0] != 2'b11) begin
         f.illegal = 1; f.wen = 0; f.mem_wen = 0; f.branch_op = 0; f.jal = 0;
      end
`endif
      return f;
   endfunction

   function automatic fields_t obs_fields();
      fields_t f;
      f.pc = bus.out_PC; f.rs1 = bus.read_sel1; f.rs2 = bus.read_sel2; f.rd = bus.write_sel;
      f.wen = bus.wEn; f.mem_wen = bus.mem_wEn; f.wb_sel = bus.wb_sel; f.branch_op = bus.branch_op;
      f.op_a = bus.op_A_sel; f.op_b = bus.op_B_sel; f.imm = bus.imm32; f.alu = bus.ALU_Control;
      f.jal = bus.jal_taken; f.jtgt = bus.JAL_target; f.illegal = bus.illegal;
      return f;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_out = '0; m_out.pc = RST_PC; m_opc = '0;
      m_pending = 0; m_rd = '0; m_stall = '0;
   endtask

   task automatic put(input logic v, input logic [31:0] ins, input logic [15:0] pc,
                      input logic ordy, input logic fl);
      bus.in_valid = v; bus.in_instruction = ins; bus.in_PC = pc;
      bus.out_ready = ordy; bus.flush = fl;
   endtask

   // Advance one clock: sample in_ready before the edge, then step the model at the edge.
   task automatic cycle();
      logic v, fl, ordy, haz, acc, xfer, pend;
      logic [31:0] ins;
      logic [15:0] pc;
      @(negedge clock);
      v = bus.in_valid; ins = bus.in_instruction; pc = bus.in_PC;
      fl = bus.flush; ordy = bus.out_ready;
      haz = m_pending && v && ((uses1(ins[6:0]) && ins[19:15] == m_rd) ||
                               (uses2(ins[6:0]) && ins[24:20] == m_rd));
      exp_ready = !reset && (!m_valid || ordy) && !haz && !fl;
      obs_ready = bus.in_ready;
      acc = v && exp_ready;
      xfer = m_valid && ordy;
      @(posedge clock);
      if (fl) begin
         m_valid = 0; m_pending = 0;
      end else begin
         pend = xfer && m_opc == OP_LOAD && m_out.rd != 0;
         if (pend) m_rd = m_out.rd;
         m_pending = pend;
         if (acc) begin
            m_out = ref_decode(ins, pc); m_opc = ins[6:0]; m_valid = 1;
         end else if (xfer) m_valid = 0;
         if (haz && m_stall != 4'hF) m_stall = m_stall + 4'd1;
      end
      #1;
   endtask

   task automatic idle(input int n);
      put(0, 32'd0, 16'd0, 1, 0);
      repeat (n) cycle();
   endtask

   task automatic test_reset();
      fields_t f;
      reset = 1; put(0, 32'd0, 16'd0, 1, 0);
      #2;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
      @(posedge clock); @(posedge clock); #1;
      model_reset();
      f = obs_fields();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (f !== m_out) begin errors++; $display("FAIL reset_fields: got %h want %h", f, m_out); end
      checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", bus.stall_count); end
      @(negedge clock); reset = 0; #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
      @(posedge clock); #1;
   endtask

   task automatic test_addi();
      fields_t f;
      put(1, 32'h00700293, 16'h0020, 1, 0); cycle();
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL addi_ready: got %b want 1", obs_ready); end
      checks++;
      if ({bus.out_valid, bus.write_sel, bus.imm32, bus.ALU_Control, bus.op_B_sel, bus.wEn} !==
          {1'b1, 5'd5, 32'd7, 6'b000000, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL addi_fields: got v=%b rd=%0d imm=%h alu=%b opb=%b wen=%b want v=1 rd=5 imm=7 alu=000000 opb=1 wen=1",
                  bus.out_valid, bus.write_sel, bus.imm32, bus.ALU_Control, bus.op_B_sel, bus.wEn);
      end
      f = obs_fields();
      checks++; if (f !== m_out) begin errors++; $display("FAIL addi_model: got %h want %h", f, m_out); end
      idle(1);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_load_use(input logic [31:0] ld, input logic [31:0] use_ins,
                                input int want, input string name);
      logic [3:0] s0;
      int         bubbles;
      bit         done;
      s0 = m_stall;
      put(1, ld, 16'h0100, 1, 0); cycle();
      put(1, ADDI8, 16'h0104, 1, 0); cycle();
      put(1, use_ins, 16'h0108, 1, 0);
      bubbles = 0; done = 0;
      for (int i = 0; i < 4 && !done; i++) begin
         cycle();
         if (obs_ready) done = 1; else bubbles++;
      end
      checks++; if (!done || bubbles != want) begin errors++; $display("FAIL %s_bubbles: got %0d (accepted=%0d) want %0d", name, bubbles, done, want); end
      checks++; if (bus.stall_count !== s0 + 4'(want)) begin errors++; $display("FAIL %s_stall: got %0d want %0d", name, bus.stall_count, s0 + 4'(want)); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_PC !== 16'h0108) begin errors++; $display("FAIL %s_issue: got v=%b pc=%h want v=1 pc=0108", name, bus.out_valid, bus.out_PC); end
      idle(2);
   endtask

   task automatic test_backpressure();
      fields_t hold, f;
      put(1, 32'h00700293, 16'h0030, 1, 0); cycle();
      hold = m_out;
      put(1, 32'h00100493, 16'h0034, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         f = obs_fields();
         checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 0", i, obs_ready); end
         checks++; if (f !== hold || bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_fields[%0d]: got %h v=%b want %h v=1", i, f, bus.out_valid, hold); end
      end
      for (int k = 0; k < 4; k++) begin
         put(1, 32'h00000493 | (32'(k) << 20), 16'h0034 + 16'(4 * k), 1, 0); cycle();
         checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", k, obs_ready); end
         checks++; if (bus.out_valid !== 1'b1 || bus.out_PC !== 16'h0034 + 16'(4 * k) || bus.imm32 !== 32'(k)) begin
            errors++; $display("FAIL stream_out[%0d]: got v=%b pc=%h imm=%h want v=1 pc=%h imm=%h",
                               k, bus.out_valid, bus.out_PC, bus.imm32, 16'h0034 + 16'(4 * k), 32'(k));
         end
      end
      idle(2);
   endtask

   task automatic test_flush();
      logic [3:0] s0;
      s0 = m_stall;
      put(1, LW_X6, 16'h0200, 1, 0); cycle();
      put(1, ADDI8, 16'h0204, 1, 0); cycle();
      put(1, ADD_X6, 16'h0208, 1, 1); cycle();
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", obs_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
      put(1, ADD_X6, 16'h0208, 1, 0); cycle();
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL flush_no_bubble: got %b want 1", obs_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_PC !== 16'h0208) begin errors++; $display("FAIL flush_issue: got v=%b pc=%h want v=1 pc=0208", bus.out_valid, bus.out_PC); end
      checks++; if (bus.stall_count !== s0) begin errors++; $display("FAIL flush_stall: got %0d want %0d", bus.stall_count, s0); end
      idle(2);
   endtask

   task automatic test_jal();
      fields_t f;
      put(1, 32'h008000EF, 16'h0010, 1, 0); cycle();
      checks++; if ({bus.out_valid, bus.jal_taken, bus.JAL_target, bus.op_A_sel} !== {1'b1, 1'b1, 16'h0018, 2'b10}) begin
         errors++; $display("FAIL jal: got v=%b jal=%b tgt=%h opa=%b want v=1 jal=1 tgt=0018 opa=10",
                            bus.out_valid, bus.jal_taken, bus.JAL_target, bus.op_A_sel);
      end
      f = obs_fields();
      checks++; if (f !== m_out) begin errors++; $display("FAIL jal_model: got %h want %h", f, m_out); end
      idle(1);
   endtask

   task automatic test_illegal();
      put(1, 32'h0000007F, 16'h0040, 1, 0); cycle();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL illegal_flow: got %b want 1", bus.out_valid); end
`ifdef DECODE_ILLEGAL_TRAP_EN
      checks++; if ({bus.illegal, bus.wEn, bus.mem_wEn} !== 3'b100) begin errors++; $display("FAIL illegal_trap: got ill=%b wen=%b mwen=%b want 1 0 0", bus.illegal, bus.wEn, bus.mem_wEn); end
`else
      checks++; if ({bus.illegal, bus.ALU_Control} !== {1'b0, 6'b111111}) begin errors++; $display("FAIL illegal_default: got ill=%b alu=%b want 0 111111", bus.illegal, bus.ALU_Control); end
`endif
      idle(1);
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 16; i++) begin
         put(1, LW_X6, 16'h0400, 1, 0); cycle();
         put(1, ADDI8, 16'h0404, 1, 0); cycle();
         put(1, ADD_X6, 16'h0408, 1, 0); cycle(); cycle();
      end
      idle(2);
      checks++; if (bus.stall_count !== 4'hF) begin errors++; $display("FAIL stall_saturate: got %0d want 15", bus.stall_count); end
   endtask

   task automatic test_reset_midstream();
      fields_t f;
      put(1, LW_X6, 16'h0300, 1, 0); cycle();
      put(1, ADDI8, 16'h0304, 1, 0); cycle();
      put(1, ADD_X6, 16'h0308, 1, 0);
      #3; reset = 1; #1;
      checks++; if ({bus.out_valid, bus.stall_count, bus.in_ready} !== {1'b0, 4'd0, 1'b0}) begin
         errors++; $display("FAIL midreset: got v=%b stall=%0d rdy=%b want v=0 stall=0 rdy=0", bus.out_valid, bus.stall_count, bus.in_ready);
      end
      model_reset();
      @(posedge clock); #1;
      reset = 0; #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_release: got %b want 1", bus.in_ready); end
      cycle();
      f = obs_fields();
      checks++; if (bus.out_valid !== 1'b1 || f !== m_out) begin errors++; $display("FAIL midreset_issue: got v=%b %h want v=1 %h", bus.out_valid, f, m_out); end
      idle(2);
   endtask

   task automatic test_random();
      logic [6:0]  ops [12];
      logic [31:0] ins;
      fields_t     f;
      ops = '{OP_R, OP_I, OP_LOAD, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
              OP_AUIPC, OP_LUI, 7'h7F, 7'h08};
      for (int i = 0; i < 600; i++) begin
         ins = $urandom;
         ins[6:0]   = ops[$urandom_range(0, 11)];
         ins[11:7]  = 5'($urandom_range(0, 3));
         ins[19:15] = 5'($urandom_range(0, 3));
         ins[24:20] = 5'($urandom_range(0, 3));
         put($urandom_range(0, 3) != 0, ins, 16'($urandom), $urandom_range(0, 9) < 7,
             $urandom_range(0, 24) == 0);
         cycle();
         f = obs_fields();
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, obs_ready, exp_ready); end
         checks++; if (bus.out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus.out_valid, m_valid); end
         checks++; if (f !== m_out) begin errors++; $display("FAIL rnd_fields[%0d]: got %h want %h", i, f, m_out); end
         checks++; if (bus.stall_count !== m_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, bus.stall_count, m_stall); end
      end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_addi();
      test_load_use(LW_X6, ADD_X6, 1, "load_use");
      test_load_use(LW_X0, ADD_X0, 0, "load_x0");
      test_backpressure();
      test_flush();
      test_jal();
      test_illegal();
      test_saturate();
      test_reset_midstream();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $fatal(1);
   end
endmodule
